// File: rtl/timer_ctrl_param.sv
// Parametrised countdown timer: prescaled ticks, restart/abort, one-shot or periodic, flicker window.
// Optional pause support is compiled in with TIMER_PAUSE_EN.
module timer_ctrl_param #(
    parameter int LEN_W        = 8,
    parameter int TICK_DIV     = 1,
    parameter int FLICKER_LAST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_start,
    input  logic             t_stop,
    input  logic             t_pause,
    input  logic             t_reload,
    input  logic [LEN_W-1:0] t_length,
    output logic             t_busy,
    output logic [LEN_W-1:0] t_remaining,
    output logic             t_flicker,
    output logic             t_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

`ifdef TIMER_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam state_t HOLD_ST = PAUSE;
    logic hold;
    assign hold = t_pause;
`else
    typedef enum logic {IDLE, RUN} state_t;
    localparam state_t HOLD_ST = RUN;
    logic hold;
    // pause is kept on the port list but has no effect in this build
    assign hold = t_pause & 1'b0;
`endif

    state_t           state;
    logic [PW-1:0]    prescaler;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;

    logic             tick;
    logic [LEN_W-1:0] rem_dec;
    logic             new_in_win;
    logic             old_in_win;

    assign tick       = (prescaler == PS_LAST);
    assign rem_dec    = t_remaining - 1'b1;
    assign new_in_win = (FLICKER_LAST != 0) && (32'(rem_dec) <= FLICKER_LAST);
    assign old_in_win = (FLICKER_LAST != 0) && (32'(t_remaining) <= FLICKER_LAST);

    always_ff @(posedge clk) begin
        t_done <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            t_busy      <= 1'b0;
            t_remaining <= '0;
            t_flicker   <= 1'b0;
            prescaler   <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
        end else if (t_stop) begin
            state       <= IDLE;
            t_busy      <= 1'b0;
            t_remaining <= '0;
            t_flicker   <= 1'b0;
            prescaler   <= '0;
        end else if (t_start) begin
            prescaler <= '0;
            t_flicker <= 1'b0;
            if (t_length != '0) begin
                len_q       <= t_length;
                mode_q      <= t_reload;
                t_remaining <= t_length;
                state       <= RUN;
                t_busy      <= 1'b1;
            end else begin
                state       <= IDLE;
                t_busy      <= 1'b0;
                t_remaining <= '0;
                t_done      <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    t_busy <= 1'b0;
                end
                default: begin
                    // a resuming cycle counts like any other RUN cycle
                    if (hold) begin
                        state <= HOLD_ST;
                    end else begin
                        state <= RUN;
                        if (!tick) begin
                            prescaler <= prescaler + 1'b1;
                        end else begin
                            prescaler <= '0;
                            if (t_remaining == LEN_W'(1)) begin
                                t_done    <= 1'b1;
                                t_flicker <= 1'b0;
                                if (mode_q) begin
                                    t_remaining <= len_q;
                                end else begin
                                    t_remaining <= '0;
                                    state       <= IDLE;
                                    t_busy      <= 1'b0;
                                end
                            end else begin
                                t_remaining <= rem_dec;
                                if (new_in_win)
                                    t_flicker <= old_in_win ? ~t_flicker : 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl_param.sv
// Directed bench for timer_ctrl_param: vector table plus multi-cycle sequences.
// dut1 uses defaults (TICK_DIV=1, FLICKER_LAST=4); dut4 uses TICK_DIV=4, FLICKER_LAST=2.
module tb_timer_ctrl_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       t_start, t_stop, t_pause, t_reload;
    logic [7:0] t_length;

    logic       busy1, fl1, done1;
    logic [7:0] rem1;
    logic       busy4, fl4, done4;
    logic [7:0] rem4;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_ctrl_param #(.LEN_W(8), .TICK_DIV(1), .FLICKER_LAST(4)) dut1 (
        .clk(clk), .reset(reset), .t_start(t_start), .t_stop(t_stop),
        .t_pause(t_pause), .t_reload(t_reload), .t_length(t_length),
        .t_busy(busy1), .t_remaining(rem1), .t_flicker(fl1), .t_done(done1)
    );

    timer_ctrl_param #(.LEN_W(8), .TICK_DIV(4), .FLICKER_LAST(2)) dut4 (
        .clk(clk), .reset(reset), .t_start(t_start), .t_stop(t_stop),
        .t_pause(t_pause), .t_reload(t_reload), .t_length(t_length),
        .t_busy(busy4), .t_remaining(rem4), .t_flicker(fl4), .t_done(done4)
    );

    typedef struct {
        logic       start, stop, pause, reload;
        logic [7:0] len;
        logic       busy;
        logic [7:0] rem;
        logic       fl;
        logic       done;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic s, logic p, logic ps, logic rl,
                                logic [7:0] l, logic b, logic [7:0] r,
                                logic f, logic d);
        vec_t v;
        v.start = s; v.stop = p; v.pause = ps; v.reload = rl; v.len = l;
        v.busy = b; v.rem = r; v.fl = f; v.done = d;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        t_start = 0; t_stop = 0; t_pause = 0; t_reload = 0; t_length = 0;
    endtask

    task automatic stop_all;
        clear_in();
        t_stop = 1;
        cyc();
        t_stop = 0;
    endtask

    initial begin
        int done_at;
        int pulses;

        clear_in();
        reset = 1;
        cyc();
        chk("rst_busy1", busy1, 0);
        chk("rst_rem1", rem1, 0);
        chk("rst_fl1", fl1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_rem4", rem4, 0);
        reset = 0;
        cyc();

        // one-shot, length 10
        add(1,0,0,0,10, 1,10,0,0);
        add(0,0,0,0,0,  1,9,0,0);
        add(0,0,0,0,0,  1,8,0,0);
        add(0,0,0,0,0,  1,7,0,0);
        add(0,0,0,0,0,  1,6,0,0);
        add(0,0,0,0,0,  1,5,0,0);
        add(0,0,0,0,0,  1,4,1,0);
        add(0,0,0,0,0,  1,3,0,0);
        add(0,0,0,0,0,  1,2,1,0);
        add(0,0,0,0,0,  1,1,0,0);
        add(0,0,0,0,0,  0,0,0,1);
        add(0,0,0,0,0,  0,0,0,0);
        // periodic, length 5, four periods then abort
        add(1,0,0,1,5,  1,5,0,0);
        for (int p = 0; p < 4; p++) begin
            add(0,0,0,0,0, 1,4,1,0);
            add(0,0,0,0,0, 1,3,0,0);
            add(0,0,0,0,0, 1,2,1,0);
            add(0,0,0,0,0, 1,1,0,0);
            add(0,0,0,0,0, 1,5,0,1);
        end
        add(0,1,0,0,0,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            t_start  = vq[i].start;
            t_stop   = vq[i].stop;
            t_pause  = vq[i].pause;
            t_reload = vq[i].reload;
            t_length = vq[i].len;
            cyc();
            chk($sformatf("vec%0d_busy", i), busy1, vq[i].busy);
            chk($sformatf("vec%0d_rem", i), rem1, vq[i].rem);
            chk($sformatf("vec%0d_flicker", i), fl1, vq[i].fl);
            chk($sformatf("vec%0d_done", i), done1, vq[i].done);
        end
        clear_in();

        // prescaled run on dut4
        stop_all();
        t_start = 1; t_length = 3;
        cyc();
        clear_in();
        chk("div4_start_rem", rem4, 3);
        done_at = -1;
        for (int t = 1; t <= 14; t++) begin
            cyc();
            if (t == 3) chk("div4_t3_rem", rem4, 3);
            if (t == 4) begin
                chk("div4_t4_rem", rem4, 2);
                chk("div4_t4_fl", fl4, 1);
            end
            if (t == 8) begin
                chk("div4_t8_rem", rem4, 1);
                chk("div4_t8_fl", fl4, 0);
            end
            if (t == 12) chk("div4_t12_busy", busy4, 0);
            if (done4 && done_at < 0) done_at = t;
        end
        chk("div4_done_at", done_at, 12);

        // pause for 7 cycles at remaining 6
        stop_all();
        t_start = 1; t_length = 10;
        cyc();
        clear_in();
        done_at = -1;
        pulses  = 0;
        for (int t = 1; t <= 30; t++) begin
            t_pause = (t >= 5 && t <= 11);
            cyc();
            if (t == 8) begin
`ifdef TIMER_PAUSE_EN
                chk("pause_rem_held", rem1, 6);
`else
                chk("pause_rem_ignored", rem1, 2);
`endif
                chk("pause_busy", busy1, 1);
            end
            if (done1) begin
                pulses++;
                if (done_at < 0) done_at = t;
            end
        end
        t_pause = 0;
`ifdef TIMER_PAUSE_EN
        chk("pause_done_at", done_at, 17);
`else
        chk("pause_done_at", done_at, 10);
`endif
        chk("pause_pulses", pulses, 1);

        // restart with length 20 at remaining 3
        stop_all();
        t_start = 1; t_length = 10;
        cyc();
        clear_in();
        for (int t = 1; t <= 7; t++) cyc();
        chk("restart_pre_rem", rem1, 3);
        t_start = 1; t_length = 20;
        cyc();
        clear_in();
        chk("restart_rem", rem1, 20);
        chk("restart_done", done1, 0);
        chk("restart_busy", busy1, 1);
        cyc();
        chk("restart_rem_next", rem1, 19);
        pulses = 0;
        for (int t = 2; t <= 19; t++) begin
            cyc();
            if (done1) pulses++;
        end
        chk("restart_no_early_done", pulses, 0);
        cyc();
        chk("restart_done_at_20", done1, 1);

        // zero-length start from IDLE
        stop_all();
        t_start = 1; t_length = 0;
        cyc();
        clear_in();
        chk("zero_done", done1, 1);
        chk("zero_busy", busy1, 0);
        chk("zero_rem", rem1, 0);
        cyc();
        chk("zero_done_single", done1, 0);

        // zero-length restart from RUN
        t_start = 1; t_length = 10;
        cyc();
        clear_in();
        cyc();
        t_start = 1; t_length = 0;
        cyc();
        clear_in();
        chk("zero_rs_done", done1, 1);
        chk("zero_rs_busy", busy1, 0);
        chk("zero_rs_rem", rem1, 0);

        // reset mid-run at remaining 4
        stop_all();
        t_start = 1; t_length = 10;
        cyc();
        clear_in();
        for (int t = 1; t <= 6; t++) cyc();
        chk("mid_rst_pre_rem", rem1, 4);
        chk("mid_rst_pre_fl", fl1, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_rem", rem1, 0);
        chk("mid_rst_fl", fl1, 0);
        chk("mid_rst_done", done1, 0);

        // same-cycle stop and start
        t_start = 1; t_length = 10;
        cyc();
        clear_in();
        cyc();
        t_start = 1; t_stop = 1; t_length = 7;
        cyc();
        clear_in();
        chk("stopstart_busy", busy1, 0);
        chk("stopstart_rem", rem1, 0);
        chk("stopstart_done", done1, 0);
        cyc();
        chk("stopstart_idle_done", done1, 0);
        chk("stopstart_idle_busy", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
